muldiv_hilo: RTL

- Sequential multiply/divide unit that owns the architectural HI/LO registers.
- Sits directly downstream of the combinational MULT32 (signed) and MULT32_U (unsigned) multipliers:
  - It registers operands and drives them into both multipliers.
  - It captures their HI/LO products after a fixed latency.
- It also implements its own iterative 32-cycle restoring divider.
- BUSY stalls the pipeline on MFHI/MFLO until results are written.

---
 rtl/muldiv_hilo.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: multiply/divide unit owning the architectural HI/LO registers.
// Multiplies are done by external combinational MULT32/MULT32_U blocks fed from
// registered operands. Divides use an internal 32-iteration restoring divider.
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   START, OP, A, B               request strobe, opcode, operands
//   MUL_A, MUL_B                  registered operands to both multipliers
//   MULS_HI/LO, MULU_HI/LO        signed / unsigned products from the multipliers
//   HI, LO                        architectural result registers
//   BUSY, DONE, DIV_BY_ZERO       status: in flight, completion pulse, zero divisor
module muldiv_hilo #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [2:0]  OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] MUL_A,
  output logic [31:0] MUL_B,
  input  logic [31:0] MULS_HI,
  input  logic [31:0] MULS_LO,
  input  logic [31:0] MULU_HI,
  input  logic [31:0] MULU_LO,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        BUSY,
  output logic        DONE,
  output logic        DIV_BY_ZERO
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_RUN  = 2'd2,
    DIV_FIX  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mul_signed;
  logic             div_zero;
  logic             neg_q;
  logic             neg_r;
  logic [W-1:0]     rem;
  logic [W-1:0]     quo;
  logic [W-1:0]     dvsr;

  // Operand magnitudes for signed DIV; DIVU passes raw operands through.
  logic         is_div_s;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;

  always_comb begin
    is_div_s = (OP == OP_DIV);
    a_mag    = (is_div_s && A[W-1]) ? W'(~A + W'(1)) : A;
    b_mag    = (is_div_s && B[W-1]) ? W'(~B + W'(1)) : B;
  end

  // One restoring step: shift in the next dividend bit, then trial subtract.
  // Borrow out of bit W means the divisor did not fit.
  logic [W:0] shifted;
  logic [W:0] diff;
  logic       fits;

  always_comb begin
    shifted = {rem, quo[W-1]};
    diff    = shifted - {1'b0, dvsr};
    fits    = ~diff[W];
  end

  // Sign correction applied in DIV_FIX.
  logic [W-1:0] q_fixed;
  logic [W-1:0] r_fixed;

  always_comb begin
    q_fixed = neg_q ? W'(~quo + W'(1)) : quo;
    r_fixed = neg_r ? W'(~rem + W'(1)) : rem;
  end

  // Control state, operand capture and result write-back.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      mul_signed  <= 1'b0;
      div_zero    <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      MUL_A       <= '0;
      MUL_B       <= '0;
      HI          <= '0;
      LO          <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      DIV_BY_ZERO <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            case (OP)
              OP_MULT, OP_MULTU: begin
                MUL_A       <= A;
                MUL_B       <= B;
                mul_signed  <= (OP == OP_MULT);
                cnt         <= CNT_W'(MUL_LAT - 1);
                BUSY        <= 1'b1;
                DIV_BY_ZERO <= 1'b0;
                state       <= MUL_WAIT;
              end
              OP_DIV, OP_DIVU: begin
                BUSY        <= 1'b1;
                DIV_BY_ZERO <= 1'b0;
                rem         <= '0;
                dvsr        <= b_mag;
                cnt         <= CNT_W'(W - 1);
                neg_q       <= is_div_s && (A[W-1] ^ B[W-1]);
                neg_r       <= is_div_s && A[W-1];
                // A zero divisor bypasses the iterations; quo keeps raw A for HI.
                if (B == '0) begin
                  div_zero <= 1'b1;
                  quo      <= A;
                  state    <= DIV_FIX;
                end else begin
                  div_zero <= 1'b0;
                  quo      <= a_mag;
                  state    <= DIV_RUN;
                end
              end
              OP_MTHI: begin
                HI          <= A;
                DONE        <= 1'b1;
                DIV_BY_ZERO <= 1'b0;
              end
              OP_MTLO: begin
                LO          <= A;
                DONE        <= 1'b1;
                DIV_BY_ZERO <= 1'b0;
              end
              default: ;
            endcase
          end
        end

        MUL_WAIT: begin
          if (cnt == '0) begin
            HI    <= mul_signed ? MULS_HI : MULU_HI;
            LO    <= mul_signed ? MULS_LO : MULU_LO;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DIV_RUN: begin
          rem <= fits ? diff[W-1:0] : shifted[W-1:0];
          quo <= {quo[W-2:0], fits};
          if (cnt == '0) begin
            state <= DIV_FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DIV_FIX: begin
          if (div_zero) begin
            HI          <= quo;
            LO          <= '1;
            DIV_BY_ZERO <= 1'b1;
          end else begin
            HI <= r_fixed;
            LO <= q_fixed;
          end
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
